// File: rtl/seq_rotator_if.sv
// Request/result handshake bundle for seq_rotator.
// The slave side is the rotator; the master side is the producer/consumer.
interface seq_rotator_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_mode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic        busy;

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, flush, out_ready,
        output in_ready, out_valid, out_data, out_zero, busy
    );

    modport master (
        output in_valid, in_data, in_amt, in_mode, flush, out_ready,
        input  in_ready, out_valid, out_data, out_zero, busy
    );
endinterface

// File: rtl/seq_rotator.sv
// Multi-cycle 16-bit rotator/shifter: one bit per clock, then holds the
// result until the consumer takes it.
module seq_rotator (
    input  logic         clk,
    input  logic         rst_n,
    seq_rotator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_ROR = 2'b00,
        MODE_SRL = 2'b01,
        MODE_ROL = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    state_e      state_q, state_d;
    logic [15:0] work_q,  work_d;
    logic [3:0]  cnt_q,   cnt_d;
    mode_e       mode_q,  mode_d;
    logic        armed_q;

    function automatic logic [15:0] step_once(input logic [15:0] w, input mode_e m);
        logic [15:0] r;
        unique case (m)
            MODE_SRL: r = {1'b0, w[15:1]};
            MODE_ROL: r = {w[14:0], w[15]};
            default:  r = {w[0], w[15:1]};   // ROR, and the reserved encoding
        endcase
        return r;
    endfunction

    // armed_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_ROR;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        if (bus.flush) begin
            state_d = IDLE;
            work_d  = '0;
            cnt_d   = '0;
            mode_d  = MODE_ROR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        work_d  = bus.in_data;
                        cnt_d   = bus.in_amt;
                        mode_d  = mode_e'(bus.in_mode);
                        state_d = (bus.in_amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    work_d = step_once(work_q, mode_q);
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = armed_q && (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.out_data  = work_q;
        bus.out_zero  = (work_q == '0);
    end

    a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready && !bus.flush) |=> (bus.out_valid && $stable(bus.out_data)));

    a_ready_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        bus.in_ready |-> !bus.busy);

endmodule
